// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer signal bundle: control, instruction-memory read port and decode handshake.
// The sequencer connects through the master modport, its environment through the slave modport.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              start;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              busy;
  logic              halted;
  logic [15:0]       fetch_count;

  modport master (
    input  start, imem_rdata, redirect_valid, redirect_pc, instr_ready,
    output imem_en, imem_addr, instr_valid, instr, instr_pc, busy, halted, fetch_count
  );

  modport slave (
    output start, imem_rdata, redirect_valid, redirect_pc, instr_ready,
    input  imem_en, imem_addr, instr_valid, instr, instr_pc, busy, halted, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the pc, reads one word per instruction after a fixed
// memory latency, and hands it to decode over valid/ready with redirect and halt support.
//   state   | meaning
//   IDLE    | waiting for start after reset
//   FETCH   | imem_en pulse for the current pc
//   WAIT    | counting down the memory latency, capture on the last cycle
//   VALID   | instruction presented to decode until accepted
//   HALTED  | halt word accepted, waiting for start
module fetch_sequencer #(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 32,
  parameter int                MEM_LAT   = 1,
  parameter logic [ADDR_W-1:0] START_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_VALID, S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [15:0]       count_q, count_d;
  logic              accept;
  logic              active;

  assign accept = (state_q == S_VALID) && bus.instr_ready;
  assign active = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_VALID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= START_PC;
      cnt_q      <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;

    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          pc_d    = START_PC;
          count_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        if (accept) begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (instr_q == HALT_WORD) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides halt and discards any read in flight, including one landing now.
    if (bus.redirect_valid && active) begin
      pc_d       = bus.redirect_pc;
      state_d    = S_FETCH;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
    end
  end

  assign bus.imem_en     = (state_q == S_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == S_VALID);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.busy        = active;
  assign bus.halted      = (state_q == S_HALTED);
  assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: stimulus queues expected fetch addresses and transfers,
// negedge monitors pop and compare them whenever the DUT strobes imem_en or completes a transfer.
module tb_fetch_sequencer;
  localparam logic [31:0] WA = 32'hA000_000A;
  localparam logic [31:0] WB = 32'hB000_000B;
  localparam logic [31:0] WC = 32'hC000_000C;
  localparam logic [31:0] WD = 32'hD000_0014;
  localparam logic [31:0] WE = 32'hE000_0028;
  localparam logic [31:0] WF = 32'hF000_003E;
  localparam logic [31:0] WG = 32'h6000_003F;
  localparam logic [31:0] W5 = 32'h5555_0005;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [5:0]  exp_addr[$];
  logic [37:0] exp_xfer[$];
  logic [31:0] mem[64];

  fetch_sequencer_if #(.ADDR_W(6), .DATA_W(32)) ifc ();

  fetch_sequencer #(.ADDR_W(6), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory; off-cycle data is poisoned so mistimed captures show up.
  always @(posedge clk)
    ifc.imem_rdata <= ifc.imem_en ? mem[ifc.imem_addr] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.imem_en === 1'b1) begin
      if (exp_addr.size() == 0) chk("unexpected_fetch", 38'(ifc.imem_addr), 38'h3F_FFFF_FFFF);
      else chk("fetch_addr", 38'(ifc.imem_addr), 38'(exp_addr.pop_front()));
    end
    if (ifc.instr_valid === 1'b1 && ifc.instr_ready === 1'b1) begin
      if (exp_xfer.size() == 0) chk("unexpected_xfer", {ifc.instr_pc, ifc.instr}, '1);
      else chk("xfer", {ifc.instr_pc, ifc.instr}, exp_xfer.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xfer(input logic [5:0] pc, input logic [31:0] w);
    exp_xfer.push_back({pc, w});
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (ifc.instr_valid !== 1'b1 && n < 30) begin tick(); n++; end
    chk(name, 38'(ifc.instr_valid), 38'd1);
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (ifc.halted !== 1'b1 && n < 60) begin tick(); n++; end
    chk(name, 38'(ifc.halted), 38'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 + 32'(i);
    mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = HALT;
    mem[5] = W5; mem[20] = WD; mem[21] = HALT; mem[40] = WE;
    mem[62] = WF; mem[63] = WG;

    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    ifc.instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_imem_en", 38'(ifc.imem_en), 38'd0);
    chk("rst_addr", 38'(ifc.imem_addr), 38'd0);
    chk("rst_valid", 38'(ifc.instr_valid), 38'd0);
    chk("rst_busy_halted", {ifc.busy, ifc.halted}, 38'd0);
    chk("rst_count", 38'(ifc.fetch_count), 38'd0);
    chk("rst_instr", {ifc.instr_pc, ifc.instr}, 38'd0);

    // Streaming with ready high: fetch every 3 cycles, halt word at pc 3.
    for (int a = 0; a < 4; a++) exp_addr.push_back(6'(a));
    push_xfer(0, WA); push_xfer(1, WB); push_xfer(2, WC); push_xfer(3, HALT);
    ifc.instr_ready = 1'b1;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("stream_en_c%0d", k), 38'(ifc.imem_en), 38'(k % 3 == 1));
      chk($sformatf("stream_valid_c%0d", k), 38'(ifc.instr_valid), 38'(k % 3 == 0));
      tick();
    end
    chk("stream_count3", 38'(ifc.fetch_count), 38'd3);
    wait_halted("halt_reached");
    chk("halt_busy", 38'(ifc.busy), 38'd0);
    chk("halt_count4", 38'(ifc.fetch_count), 38'd4);
    tick(); tick(); tick();
    chk("halt_no_fetch", 38'(ifc.imem_en), 38'd0);

    // Restart from HALTED with back-pressure.
    ifc.instr_ready = 1'b0;
    exp_addr.push_back(6'd0);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("restart_count_clr", 38'(ifc.fetch_count), 38'd0);
    chk("restart_state", {ifc.busy, ifc.halted}, 38'b10);
    wait_valid("hold_valid");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_instr", {ifc.instr_pc, ifc.instr}, {6'd0, WA});
      chk("hold_no_en", {ifc.instr_valid, ifc.imem_en}, 38'b10);
    end
    push_xfer(0, WA);
    exp_addr.push_back(6'd1);
    ifc.instr_ready = 1'b1;
    tick();
    ifc.instr_ready = 1'b0;
    chk("after_accept_fetch", {ifc.imem_en, ifc.imem_addr}, {1'b1, 6'd1});
    wait_valid("b_valid");
    chk("b_instr", {ifc.instr_pc, ifc.instr}, {6'd1, WB});

    // Redirect in VALID without acceptance drops B; then redirect again during WAIT of pc 5.
    exp_addr.push_back(6'd5);
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 6'd5;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("redir_drop", {ifc.instr_valid, ifc.imem_en, ifc.imem_addr}, {2'b01, 6'd5});
    tick();
    chk("wait5_state", {ifc.busy, ifc.imem_en}, 38'b10);
    exp_addr.push_back(6'd20);
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 6'd20;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("redir_wait", {ifc.instr_valid, ifc.imem_en, ifc.imem_addr}, {2'b01, 6'd20});
    wait_valid("d_valid");
    chk("d_instr", {ifc.instr_pc, ifc.instr}, {6'd20, WD});

    // Accept D, then redirect while accepting the halt word at pc 21.
    push_xfer(20, WD);
    exp_addr.push_back(6'd21);
    ifc.instr_ready = 1'b1;
    tick();
    ifc.instr_ready = 1'b0;
    wait_valid("halt21_valid");
    chk("halt21_instr", {ifc.instr_pc, ifc.instr}, {6'd21, HALT});
    push_xfer(21, HALT);
    exp_addr.push_back(6'd40);
    ifc.instr_ready = 1'b1;
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 6'd40;
    tick();
    ifc.instr_ready = 1'b0;
    ifc.redirect_valid = 1'b0;
    chk("redir_beats_halt", {ifc.halted, ifc.imem_en, ifc.imem_addr}, {2'b01, 6'd40});
    wait_valid("e_valid");
    chk("e_instr", {ifc.instr_pc, ifc.instr}, {6'd40, WE});

    // Drop E by redirecting to 62, then stream through the 63 -> 0 wrap into the halt at 3.
    exp_addr.push_back(6'd62);
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 6'd62;
    tick();
    ifc.redirect_valid = 1'b0;
    exp_addr.push_back(6'd63);
    for (int a = 0; a < 4; a++) exp_addr.push_back(6'(a));
    push_xfer(62, WF); push_xfer(63, WG); push_xfer(0, WA);
    push_xfer(1, WB); push_xfer(2, WC); push_xfer(3, HALT);
    ifc.instr_ready = 1'b1;
    wait_halted("wrap_halt");
    chk("wrap_count9", 38'(ifc.fetch_count), 38'd9);

    // Reset asserted during WAIT aborts immediately; nothing appears after release.
    ifc.instr_ready = 1'b0;
    exp_addr.push_back(6'd0);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    tick();
    chk("pre_rst_wait", {ifc.busy, ifc.imem_en}, 38'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", {ifc.imem_en, ifc.instr_valid, ifc.busy, ifc.halted}, 38'd0);
    chk("mid_rst_addr", 38'(ifc.imem_addr), 38'd0);
    chk("mid_rst_instr", {ifc.instr_pc, ifc.instr}, 38'd0);
    chk("mid_rst_count", 38'(ifc.fetch_count), 38'd0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_idle", {ifc.instr_valid, ifc.busy, ifc.imem_en}, 38'd0);
    end

    chk("fetch_queue_empty", 38'(exp_addr.size()), 38'd0);
    chk("xfer_queue_empty", 38'(exp_xfer.size()), 38'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
